// File: rtl/zx_ula_timing_pkg.sv
// Shared constants and the ULA contention delay table for the ZX Spectrum 48K timing stage.
package zx_timing_pkg;

  localparam int unsigned DEF_T_PER_LINE      = 224;
  localparam int unsigned DEF_LINES_PER_FRAME = 312;
  localparam int unsigned DEF_INT_LEN         = 32;
  localparam int unsigned DEF_CONT_FIRST_LINE = 64;
  localparam int unsigned DEF_CONT_LAST_LINE  = 255;

  typedef logic [8:0] raster_t;

  // Extra T-states the ULA holds the CPU off, indexed by the low hcount bits.
  function automatic logic [2:0] contention_delay(input logic [2:0] phase);
    logic [2:0] delay;
    case (phase)
      3'd0:    delay = 3'd6;
      3'd1:    delay = 3'd5;
      3'd2:    delay = 3'd4;
      3'd3:    delay = 3'd3;
      3'd4:    delay = 3'd2;
      3'd5:    delay = 3'd1;
      default: delay = 3'd0;
    endcase
    return delay;
  endfunction

endpackage

// File: rtl/zx_ula_timing_if.sv
// CPU-facing signals of the ULA timing stage: memory request sideband in, clock-enable and interrupt out.
interface zx_ula_timing_if;

  logic       MREQ_n;
  logic [1:0] A_hi;
  logic       CLKEN;
  logic       INT_n;

  modport master (output MREQ_n, output A_hi, input CLKEN, input INT_n);
  modport slave  (input MREQ_n, input A_hi, output CLKEN, output INT_n);

endinterface

// File: rtl/zx_ula_timing_tstate_div.sv
// System-clock divider: t_en is high for one clock out of every CLK_DIV.
module zx_tstate_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic CLK_n,
  input  logic RESET_n,
  output logic t_en
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge CLK_n) begin
    if (!RESET_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_comb t_en = (div == DIV_LAST);

endmodule

// File: rtl/zx_ula_timing.sv
// ZX Spectrum 48K timing: CPU CLKEN, raster counters, frame INT_n.
// Define ZX_CONTENTION_EN to stretch CLKEN on accesses to 0x4000-0x7FFF.
module zx_ula_timing
  import zx_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned T_PER_LINE      = DEF_T_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int unsigned INT_LEN         = DEF_INT_LEN,
  parameter int unsigned CONT_FIRST_LINE = DEF_CONT_FIRST_LINE,
  parameter int unsigned CONT_LAST_LINE  = DEF_CONT_LAST_LINE
) (
  input  logic            CLK_n,
  input  logic            RESET_n,
  zx_ula_timing_if.slave  cpu,
  output raster_t         hcount,
  output raster_t         vcount,
  output logic            frame_tick
);

  localparam raster_t H_LAST  = 9'(T_PER_LINE - 1);
  localparam raster_t V_LAST  = 9'(LINES_PER_FRAME - 1);
  localparam raster_t INT_END = 9'(INT_LEN);
  localparam raster_t C_FIRST = 9'(CONT_FIRST_LINE);
  localparam raster_t C_LAST  = 9'(CONT_LAST_LINE);

  logic       t_en;
  logic       h_wrap;
  logic       v_wrap;
  logic [2:0] stall;

  zx_tstate_div #(.CLK_DIV(CLK_DIV)) u_div (
    .CLK_n   (CLK_n),
    .RESET_n (RESET_n),
    .t_en    (t_en)
  );

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
  end

  always_ff @(posedge CLK_n) begin
    if (!RESET_n) begin
      hcount     <= '0;
      vcount     <= '0;
      cpu.CLKEN  <= 1'b0;
      cpu.INT_n  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cpu.CLKEN  <= t_en && (stall == '0);
      cpu.INT_n  <= !((vcount == '0) && (hcount < INT_END));
      frame_tick <= t_en && h_wrap && v_wrap;
      if (t_en) begin
        if (h_wrap) begin
          hcount <= '0;
          vcount <= v_wrap ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

`ifdef ZX_CONTENTION_EN
  logic cont_req;

  always_comb begin
    cont_req = !cpu.MREQ_n && (cpu.A_hi == 2'b01) &&
               (vcount >= C_FIRST) && (vcount <= C_LAST) && (hcount < 9'd128);
  end

  // Counters keep running during a stall; only CLKEN is held off.
  always_ff @(posedge CLK_n) begin
    if (!RESET_n) begin
      stall <= '0;
    end else if (t_en) begin
      if (stall != '0) begin
        stall <= stall - 1'b1;
      end else if (cont_req) begin
        stall <= contention_delay(hcount[2:0]);
      end
    end
  end
`else
  logic unused_cont;

  always_comb begin
    stall       = '0;
    unused_cont = ^{cpu.MREQ_n, cpu.A_hi, C_FIRST, C_LAST};
  end
`endif

endmodule

// File: tb/tb_zx_ula_timing.sv
// Directed bench for zx_ula_timing, run with a shortened frame so whole frames fit the cycle budget.
module tb_zx_ula_timing;

  localparam int unsigned DIV  = 2;
  localparam int unsigned TPL  = 224;
  localparam int unsigned LPF  = 24;
  localparam int unsigned INTL = 32;
  localparam int unsigned CF   = 8;
  localparam int unsigned CL   = 15;
  localparam int unsigned FRAME_CLKS = TPL * LPF * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] hcount;
  logic [8:0] vcount;
  logic       frame_tick;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zx_ula_timing_if cpu_bus ();

  zx_ula_timing #(
    .CLK_DIV         (DIV),
    .T_PER_LINE      (TPL),
    .LINES_PER_FRAME (LPF),
    .INT_LEN         (INTL),
    .CONT_FIRST_LINE (CF),
    .CONT_LAST_LINE  (CL)
  ) dut (
    .CLK_n      (clk),
    .RESET_n    (rst_n),
    .cpu        (cpu_bus),
    .hcount     (hcount),
    .vcount     (vcount),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int unsigned v;
    int unsigned h;
    logic        mreq_n;
    logic [1:0]  a_hi;
    int unsigned skip;
  } cvec_t;

  cvec_t vecs[10];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_for(input int unsigned v, input int unsigned h, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (vcount == 9'(v) && hcount == 9'(h)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("wait_v%0d_h%0d_timeout", v, h), 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clken"}, int'(cpu_bus.CLKEN), 0);
    check({tag, "_int_n"}, int'(cpu_bus.INT_n), 1);
    check({tag, "_tick"},  int'(frame_tick), 0);
    check({tag, "_h"},     int'(hcount), 0);
    check({tag, "_v"},     int'(vcount), 0);
  endtask

  initial begin
    bit ok;
    int prev_clken;
    int b2b;
    int clken_cnt;
    int low_cnt;
    int last_low;
    int t1;
    int t2;
    int cnt;
    int unsigned exp_skip;

    vecs[0] = '{7,   8, 1'b0, 2'b01, 0};
    vecs[1] = '{8,   8, 1'b0, 2'b01, 6};
    vecs[2] = '{9,   3, 1'b0, 2'b01, 3};
    vecs[3] = '{9,  14, 1'b0, 2'b01, 0};
    vecs[4] = '{10,  8, 1'b0, 2'b10, 0};
    vecs[5] = '{10,130, 1'b0, 2'b01, 0};
    vecs[6] = '{11,  8, 1'b1, 2'b01, 0};
    vecs[7] = '{12,121, 1'b0, 2'b01, 5};
    vecs[8] = '{15,  0, 1'b0, 2'b01, 6};
    vecs[9] = '{16,  8, 1'b0, 2'b01, 0};

    cpu_bus.MREQ_n = 1'b1;
    cpu_bus.A_hi   = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Sample s is taken after the s-th rising edge with reset released.
    rst_n = 1'b1;
    prev_clken = 0;
    b2b = 0;
    clken_cnt = 0;
    low_cnt = 0;
    last_low = 0;
    for (int s = 1; s <= 1000; s++) begin
      @(negedge clk);
      if (s <= 6) check($sformatf("clken_s%0d", s), int'(cpu_bus.CLKEN), (s % 2 == 0) ? 1 : 0);
      if (s == 1) check("int_first_edge", int'(cpu_bus.INT_n), 0);
      if (prev_clken == 1 && cpu_bus.CLKEN) b2b++;
      prev_clken = int'(cpu_bus.CLKEN);
      if (cpu_bus.CLKEN) clken_cnt++;
      if (!cpu_bus.INT_n) begin
        low_cnt++;
        last_low = s;
      end
      if (s == 447) begin
        check("line_pre_h", int'(hcount), 223);
        check("line_pre_v", int'(vcount), 0);
      end
      if (s == 448) begin
        check("line_wrap_h", int'(hcount), 0);
        check("line_wrap_v", int'(vcount), 1);
      end
    end
    check("clken_back_to_back", b2b, 0);
    check("clken_count_1000", clken_cnt, 500);
    check("int_low_clocks", low_cnt, 2 * INTL);
    check("int_last_low", last_low, 2 * INTL);

    ok = 1'b0;
    for (int i = 0; i < FRAME_CLKS + 100; i++) begin
      @(negedge clk);
      if (frame_tick) begin ok = 1'b1; break; end
    end
    check("tick1_seen", int'(ok), 1);
    t1 = cyc;
    check("tick1_h", int'(hcount), 0);
    check("tick1_v", int'(vcount), 0);

    ok = 1'b0;
    low_cnt = 0;
    last_low = 0;
    for (int i = 1; i < FRAME_CLKS + 100; i++) begin
      @(negedge clk);
      if (frame_tick) begin ok = 1'b1; break; end
      if (!cpu_bus.INT_n) begin
        low_cnt++;
        last_low = i;
      end
    end
    check("tick2_seen", int'(ok), 1);
    t2 = cyc;
    check("frame_period", t2 - t1, FRAME_CLKS);
    check("tick2_h", int'(hcount), 0);
    check("tick2_v", int'(vcount), 0);
    check("frame_int_low", low_cnt, 2 * INTL);
    check("frame_int_last_low", last_low, 2 * INTL);

    // One request on the t_en at hcount=h, then count CLKEN over the next 8 T-states.
    for (int i = 0; i < 10; i++) begin
`ifdef ZX_CONTENTION_EN
      exp_skip = vecs[i].skip;
`else
      exp_skip = 0;
`endif
      wait_for(vecs[i].v, vecs[i].h, ok);
      if (ok) begin
        cpu_bus.MREQ_n = vecs[i].mreq_n;
        cpu_bus.A_hi   = vecs[i].a_hi;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (hcount != 9'(vecs[i].h)) break;
        end
        cpu_bus.MREQ_n = 1'b1;
        cpu_bus.A_hi   = 2'b00;
        cnt = int'(cpu_bus.CLKEN);
        repeat (15) begin
          @(negedge clk);
          cnt += int'(cpu_bus.CLKEN);
        end
        check($sformatf("cont%0d_v%0d_h%0d_clken", i, vecs[i].v, vecs[i].h), cnt, 8 - int'(exp_skip));
      end
    end

    // Reset landing in the middle of a stall.
    wait_for(CF, 8, ok);
    cpu_bus.MREQ_n = 1'b0;
    cpu_bus.A_hi   = 2'b01;
    repeat (4) @(negedge clk);
    cpu_bus.MREQ_n = 1'b1;
    cpu_bus.A_hi   = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("stall_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("stall_rst_clken_s1", int'(cpu_bus.CLKEN), 0);
    @(negedge clk);
    check("stall_rst_clken_s2", int'(cpu_bus.CLKEN), 1);

    wait_for(15, 100, ok);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_int_n", int'(cpu_bus.INT_n), 0);
    check("mid_rst_h_hold", int'(hcount), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
